// File: rtl/mem_subword_responder_if.sv
// Load/store port between the multicycle datapath (master) and the memory
// responder (slave).
interface mem_subword_responder_if;
    logic        Req;
    logic        Wr;
    logic [1:0]  Size;
    logic [31:0] Address;
    logic [31:0] Datain;
    logic        Ready;
    logic        Done;
    logic [31:0] Dataout;
    logic        Err;

    modport master (
        output Req, Wr, Size, Address, Datain,
        input  Ready, Done, Dataout, Err
    );

    modport slave (
        input  Req, Wr, Size, Address, Datain,
        output Ready, Done, Dataout, Err
    );
endinterface

// File: rtl/mem_subword_responder.sv
// Word-organised memory responder for word/halfword/byte loads and stores.
// Subword stores are done as read-modify-write; loads return zero-extended.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses complete at once
// with Err and touch nothing. Without it, offending low address bits are
// cleared and the access proceeds as aligned.
module mem_subword_responder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic                  Clk,
    input logic                  Reset,
    mem_subword_responder_if.slave bus
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_t;

    // Normalised size codes; reserved 2'b11 collapses to word.
    localparam logic [1:0] SzWord = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzByte = 2'b10;

    logic [DATA_W-1:0] mem [Depth];

    state_t            state_q;
    logic              ready_q;
    logic              done_q;
    logic [DATA_W-1:0] dataout_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] old_q;

    logic              accept;
    logic [1:0]        size_in;
    logic [1:0]        lo_in;
    logic              misalign_in;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] rd_word;
    logic [4:0]        sh;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] wr_word;

    logic unused_addr;
    assign unused_addr = ^bus.Address[31:ADDR_W+2];

    // Decode the incoming request: size normalisation, alignment, low bits.
    always_comb begin
        accept  = bus.Req && ready_q;
        size_in = (bus.Size == 2'b11) ? SzWord : bus.Size;
        unique case (size_in)
            SzHalf:  lo_in = {bus.Address[1], 1'b0};
            SzByte:  lo_in = bus.Address[1:0];
            default: lo_in = 2'b00;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        misalign_in = ((size_in == SzHalf) && bus.Address[0]) ||
                      ((size_in == SzWord) && (bus.Address[1:0] != 2'b00));
`else
        misalign_in = 1'b0;
`endif
    end

    // Lane selection for loads and the merged word for stores.
    always_comb begin
        idx     = addr_q[ADDR_W+1:2];
        rd_word = mem[idx];
        // Halfword offsets have bit 0 cleared, so one shift serves both sizes.
        sh      = {addr_q[1:0], 3'b000};
        unique case (size_q)
            SzHalf:  lane_mask = 32'h0000_FFFF << sh;
            SzByte:  lane_mask = 32'h0000_00FF << sh;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        load_val = (rd_word & lane_mask) >> sh;
        wr_word  = (old_q & ~lane_mask) | ((data_q << sh) & lane_mask);
    end

    // Control FSM with registered handshake outputs; DONE accepts like IDLE.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StIdle;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            dataout_q <= '0;
            wr_q      <= 1'b0;
            size_q    <= SzWord;
            addr_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        wr_q   <= bus.Wr;
                        size_q <= size_in;
                        addr_q <= {bus.Address[ADDR_W+1:2], lo_in};
                        data_q <= bus.Datain;
                        if (misalign_in) begin
                            state_q <= StDone;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (bus.Wr && (size_in == SzWord)) begin
                            state_q <= StWr;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= StRd;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                StRd: begin
                    old_q <= rd_word;
                    if (wr_q) begin
                        state_q <= StWr;
                        ready_q <= 1'b0;
                    end else begin
                        dataout_q <= load_val;
                        state_q   <= StDone;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b1;
                    end
                end
                StWr: begin
                    state_q <= StDone;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: written only on the edge leaving WR, never reset.
    always_ff @(posedge Clk) begin
        if (state_q == StWr) begin
            mem[idx] <= wr_word;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    // Err pulses alongside Done for a rejected misaligned access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && misalign_in;
        end
    end

    assign bus.Err = err_q;
`else
    assign bus.Err = 1'b0;
`endif

    assign bus.Ready   = ready_q;
    assign bus.Done    = done_q;
    assign bus.Dataout = dataout_q;

endmodule

// File: tb/tb_mem_subword_responder.sv
// Directed bench for mem_subword_responder. Latency is counted in cycles
// with the accept edge as cycle 1, so Done seen right after that edge is 1.
module tb_mem_subword_responder;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    mem_subword_responder_if bus ();

    mem_subword_responder #(
        .ADDR_W(8),
        .DATA_W(32)
    ) u_dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; returns load data, Err at Done and the cycle count to Done.
    task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] din, output logic [31:0] dout,
                          output logic err, output int cyc);
        bus.Req     = 1'b1;
        bus.Wr      = wr;
        bus.Size    = sz;
        bus.Address = addr;
        bus.Datain  = din;
        @(posedge Clk);
        #1;
        bus.Req = 1'b0;
        cyc = 1;
        while (!bus.Done && cyc < 10) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        dout = bus.Dataout;
        err  = bus.Err;
    endtask

    logic [31:0] d;
    logic        e;
    int          c;
    int          dones;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        Reset       = 1'b1;
        bus.Req     = 1'b0;
        bus.Wr      = 1'b0;
        bus.Size    = 2'b00;
        bus.Address = '0;
        bus.Datain  = '0;
        #22;
        check_eq("rst_ready", {31'b0, bus.Ready}, 32'd1);
        check_eq("rst_done", {31'b0, bus.Done}, 32'd0);
        check_eq("rst_err", {31'b0, bus.Err}, 32'd0);
        check_eq("rst_dataout", bus.Dataout, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // Word store/load
        access(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, d, e, c);
        check_eq("wst_lat", c, 2);
        access(1'b0, 2'b00, 32'h10, 32'h0, d, e, c);
        check_eq("wld_lat", c, 2);
        check_eq("wld_data", d, 32'hDEADBEEF);

        // Misaligned word store at 0x13
        access(1'b1, 2'b00, 32'h13, 32'hCAFEF00D, d, e, c);
`ifdef MEM_ALIGN_CHECK_EN
        check_eq("mis_lat", c, 1);
        check_eq("mis_err", {31'b0, e}, 32'd1);
        check_eq("mis_dataout_held", d, 32'hDEADBEEF);
        access(1'b0, 2'b00, 32'h10, 32'h0, d, e, c);
        check_eq("mis_unchanged", d, 32'hDEADBEEF);
`else
        check_eq("mis_lat", c, 2);
        check_eq("mis_err", {31'b0, e}, 32'd0);
        access(1'b0, 2'b00, 32'h10, 32'h0, d, e, c);
        check_eq("mis_written", d, 32'hCAFEF00D);
`endif

        // Byte store merge
        access(1'b1, 2'b00, 32'h20, 32'h11223344, d, e, c);
        access(1'b1, 2'b10, 32'h21, 32'h000000AA, d, e, c);
        check_eq("bst_lat", c, 3);
        access(1'b0, 2'b00, 32'h20, 32'h0, d, e, c);
        check_eq("bst_word", d, 32'h1122AA44);

        // Halfword store merge and subword loads
        access(1'b1, 2'b01, 32'h22, 32'h0000BEEF, d, e, c);
        check_eq("hst_lat", c, 3);
        access(1'b0, 2'b00, 32'h20, 32'h0, d, e, c);
        check_eq("hst_word", d, 32'hBEEFAA44);
        access(1'b0, 2'b10, 32'h23, 32'h0, d, e, c);
        check_eq("bld_lat", c, 2);
        check_eq("bld_data", d, 32'h000000BE);
        access(1'b0, 2'b01, 32'h20, 32'h0, d, e, c);
        check_eq("hld_data", d, 32'h0000AA44);
        access(1'b0, 2'b11, 32'h20, 32'h0, d, e, c);
        check_eq("sz11_word", d, 32'hBEEFAA44);

        // Address wraps modulo 1 KiB
        access(1'b1, 2'b00, 32'h440, 32'h12345678, d, e, c);
        access(1'b0, 2'b00, 32'h40, 32'h0, d, e, c);
        check_eq("wrap", d, 32'h12345678);

        // Req held while busy must be ignored
        access(1'b1, 2'b00, 32'h30, 32'h00000000, d, e, c);
        bus.Req     = 1'b1;
        bus.Wr      = 1'b1;
        bus.Size    = 2'b10;
        bus.Address = 32'h30;
        bus.Datain  = 32'h55;
        @(posedge Clk);
        #1;
        bus.Address = 32'h31;
        bus.Datain  = 32'h77;
        check_eq("busy_ready", {31'b0, bus.Ready}, 32'd0);
        @(posedge Clk);
        #1;
        dones = bus.Done ? 1 : 0;
        @(posedge Clk);
        #1;
        bus.Req = 1'b0;
        if (bus.Done) dones++;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) dones++;
        end
        check_eq("busy_done_count", dones, 1);
        access(1'b0, 2'b00, 32'h30, 32'h0, d, e, c);
        check_eq("busy_word", d, 32'h00000055);

        // Asynchronous reset in the middle of a load's RD state
        bus.Req     = 1'b1;
        bus.Wr      = 1'b0;
        bus.Size    = 2'b00;
        bus.Address = 32'h20;
        @(posedge Clk);
        #1;
        bus.Req = 1'b0;
        check_eq("rd_busy", {31'b0, bus.Ready}, 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("arst_ready", {31'b0, bus.Ready}, 32'd1);
        check_eq("arst_done", {31'b0, bus.Done}, 32'd0);
        check_eq("arst_dataout", bus.Dataout, 32'd0);
        @(posedge Clk);
        #1;
        check_eq("arst_no_done", {31'b0, bus.Done}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        access(1'b0, 2'b00, 32'h20, 32'h0, d, e, c);
        check_eq("post_rst_lat", c, 2);
        check_eq("post_rst_data", d, 32'hBEEFAA44);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_subword_responder.md
Name: mem_subword_responder

Overview:
- Memory-side responder for the multicycle datapath's load/store port.
- Accepts one word, halfword or byte access at a time from the datapath. Holds a word-organised storage array.
- Performs byte/halfword stores by internal read-modify-write, so the other bytes of the word are preserved.
- Returns loads zero-extended, matching the lbu/lhu MDR path. A Ready/Done handshake lets the control unit wait on variable latency.

Parameters:
- ADDR_W, 8, word-address width; array depth = 2**ADDR_W words.
- DATA_W, 32, data width; fixed at 32, byte lanes assume 4 bytes.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req  input  1  request strobe; sampled only while Ready=1.
- Wr  input  1  1=store, 0=load; sampled with Req.
- Size  input  2  00=word, 01=halfword, 10=byte, 11=reserved (treated as word).
- Address  input  32  byte address; word index = Address[ADDR_W+1:2].
- Datain  input  32  store data; subword taken from low bits ([7:0] or [15:0]).
- Ready  output  1  1 when idle and able to accept Req.
- Done  output  1  one-cycle pulse when the access completes.
- Dataout  output  32  load result; valid when Done=1 for a load; held until the next load completes.
- Err  output  1  one-cycle pulse coincident with Done for a misaligned access (feature-dependent).

Behaviour:
- Reset values: Ready=1, Done=0, Err=0, Dataout=0, FSM=IDLE. Array contents are not reset.
- Request capture: at the edge where Req=1 and Ready=1, latch Wr, Size, Address and Datain. Req while Ready=0 is ignored; it is not queued.
- Ready=1 only in IDLE, including the cycle in which Done is high.
- FSM states: IDLE, RD, WR, DONE. Edge N is the accept edge.
  - IDLE -> RD for a load or a subword store.
  - IDLE -> WR for a word store.
  - IDLE -> DONE for a misaligned access.
  - RD -> WR for a subword store.
  - RD -> DONE for a load.
  - WR -> DONE.
  - DONE -> IDLE.
- Latency, Done high during cycle:
  - word load: N+2.
  - word store: N+2.
  - subword load: N+2.
  - subword store: N+3.
  - error: N+1.
- Byte lanes, little-endian:
  - byte offset Address[1:0]=k maps to word bits [8k+7:8k].
  - halfword with Address[1]=h maps to bits [16h+15:16h].
- Loads: Dataout = selected lane, zero-extended; word = full word.
- Subword store: the RD state reads the old word. WR writes old word with only the selected lane replaced by Datain's low bits.
- Array write occurs only at the end of WR. Nothing is written in any other state.
- Address bits above ADDR_W+1 are ignored, so accesses wrap modulo the array size.
- Store then load to the same address, back-to-back: the load returns the new data. The write completes before DONE, and the next accept happens no earlier than DONE.
- Reset mid-operation: FSM returns to IDLE and Done/Err are not asserted. A store that has not reached the end of WR leaves the array unchanged, so no partial merge is possible.
- Size=11 is handled exactly as word.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - halfword with Address[0]=1 is misaligned;
  - word with Address[1:0]!=00 is misaligned;
  - a misaligned access does no read or write, goes IDLE -> DONE, asserts Done and Err together at N+1, and leaves Dataout unchanged.
- Undefined:
  - Err is tied to 0;
  - offending low address bits are forced to zero (halfword ignores bit 0, word ignores bits 1:0);
  - the access proceeds as aligned.

Test Plan:
- Reset asserted mid-RD of a load -> Ready=1, Done=0, Dataout=0 immediately (asynchronous). The next load completes normally.
- Word store 0xDEADBEEF at Address 0x10, then word load at 0x10 -> Done at N+2 for each access; Dataout=0xDEADBEEF.
- Word 0x11223344 at 0x20; byte store Datain=0x000000AA at 0x21 -> Done at N+3. Word load at 0x20 returns 0x1122AA44.
- Halfword store 0x0000BEEF at 0x22 over 0x1122AA44 -> word reads 0xBEEFAA44. Byte load at 0x23 returns 0x000000BE; halfword load at 0x20 returns 0x0000AA44.
- Req pulsed while Ready=0 during a subword store -> ignored; only one Done pulse occurs and the array changes for the first request only.
- MEM_ALIGN_CHECK_EN defined: word store at 0x13 -> Done=Err=1 at N+1 and the array is unchanged.
- MEM_ALIGN_CHECK_EN undefined: the same store writes word index 0x4 (address 0x10) with Err=0.
